// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op codes, FSM states and helpers shared by the shifter
package shifter_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_LSL  = 3'b001;
    localparam logic [2:0] OP_LSR  = 3'b010;
    localparam logic [2:0] OP_ASR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // 110/111 fall outside this range and behave as PASS
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= OP_LSL) && (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/shift_step_unit.sv
// rtl/shift_step_unit.sv - combinational shift/rotate by 0..STEP positions with carry-out
module shift_step_unit
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int CNT_W = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [2:0]       i_op,
    input  logic [CNT_W-1:0] i_count,
    output logic [WIDTH-1:0] o_shifted,
    output logic             o_carry
);

    // Linear shifts carry one extra bit so the last bit pushed out lands in it
    logic [WIDTH:0]   w_lsl;
    logic [WIDTH:0]   w_lsr;
    logic [WIDTH:0]   w_asr;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [31:0]      w_back;
    logic             w_nonzero;

    assign w_back    = 32'(WIDTH) - 32'(i_count);
    assign w_nonzero = (i_count != '0);
    assign w_lsl     = {1'b0, i_data} << i_count;
    assign w_lsr     = {i_data, 1'b0} >> i_count;
    assign w_asr     = $signed({i_data, 1'b0}) >>> i_count;
    assign w_rol     = (i_data << i_count) | (i_data >> w_back);
    assign w_ror     = (i_data >> i_count) | (i_data << w_back);

    always_comb begin
        o_shifted = i_data;
        o_carry   = 1'b0;
        case (i_op)
            OP_LSL: begin
                o_shifted = w_lsl[WIDTH-1:0];
                o_carry   = w_nonzero & w_lsl[WIDTH];
            end
            OP_LSR: begin
                o_shifted = w_lsr[WIDTH:1];
                o_carry   = w_nonzero & w_lsr[0];
            end
            OP_ASR: begin
                o_shifted = w_asr[WIDTH:1];
                o_carry   = w_nonzero & w_asr[0];
            end
            OP_ROL: begin
                o_shifted = w_rol;
                o_carry   = w_nonzero & w_rol[0];
            end
            OP_ROR: begin
                o_shifted = w_ror;
                o_carry   = w_nonzero & w_ror[WIDTH-1];
            end
            default: begin
                o_shifted = i_data;
                o_carry   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shifter iterating STEP bits per clock with valid/ready on both sides
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    localparam int CNT_W = $clog2(STEP + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_op;
    logic [AMT_W-1:0] r_rem;
    logic             r_carry;
    logic             r_zero;

    logic [CNT_W-1:0] w_cnt;
    logic [AMT_W-1:0] w_rem_next;
    logic [WIDTH-1:0] w_shifted;
    logic             w_carry;
    logic             w_accept;

    assign w_accept = in_valid && (r_state == S_IDLE);

    always_comb begin
        w_cnt = '0;
        if (32'(r_rem) > 32'(STEP)) begin
            w_cnt = CNT_W'(STEP);
        end else begin
            w_cnt = CNT_W'(r_rem);
        end
    end

    assign w_rem_next = r_rem - AMT_W'(w_cnt);

    shift_step_unit #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .CNT_W (CNT_W)
    ) u_step (
        .i_data    (r_data),
        .i_op      (r_op),
        .i_count   (w_cnt),
        .o_shifted (w_shifted),
        .o_carry   (w_carry)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if ((in_amt == '0) || !is_shift_op(in_op)) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (w_rem_next == '0) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Zero flag is captured only on entry to DONE so it stays put while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_op    <= OP_PASS;
            r_rem   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data  <= in_data;
                        r_op    <= in_op;
                        r_rem   <= in_amt;
                        r_carry <= 1'b0;
                        if (w_next_state == S_DONE) begin
                            r_zero <= (in_data == '0);
                        end
                    end
                end
                S_SHIFT: begin
                    r_data  <= w_shifted;
                    r_carry <= w_carry;
                    r_rem   <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_zero <= (w_shifted == '0);
                    end
                end
                default: begin
                    r_data <= r_data;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_data;
    assign out_carry = r_carry;
    assign out_zero  = r_zero;

endmodule
